// File: rtl/crc16_denetleyici_if.sv
// ---------------------------------------------------------------------------
// crc16_denetleyici_if
//   Byte-stream bundle around the CRC16 frame sequencer: two requester
//   streams in, one framed output stream out.
//
//   Signals
//     ist0_* / ist1_*  : requester streams (gecerli, bayt, son in; hazir out)
//     cik_*            : output stream (gecerli, bayt, son, kaynak out;
//                        hazir in from downstream)
//
//   Modports
//     slave  : the sequencer's view
//     master : the requester and downstream view (testbench / integration)
// ---------------------------------------------------------------------------
interface crc16_denetleyici_if;
  logic       ist0_gecerli_i;
  logic [7:0] ist0_bayt_i;
  logic       ist0_son_i;
  logic       ist0_hazir_o;
  logic       ist1_gecerli_i;
  logic [7:0] ist1_bayt_i;
  logic       ist1_son_i;
  logic       ist1_hazir_o;
  logic       cik_gecerli_o;
  logic [7:0] cik_bayt_o;
  logic       cik_son_o;
  logic       cik_kaynak_o;
  logic       cik_hazir_i;

  modport slave (
    input  ist0_gecerli_i, ist0_bayt_i, ist0_son_i,
    input  ist1_gecerli_i, ist1_bayt_i, ist1_son_i,
    input  cik_hazir_i,
    output ist0_hazir_o, ist1_hazir_o,
    output cik_gecerli_o, cik_bayt_o, cik_son_o, cik_kaynak_o
  );

  modport master (
    output ist0_gecerli_i, ist0_bayt_i, ist0_son_i,
    output ist1_gecerli_i, ist1_bayt_i, ist1_son_i,
    output cik_hazir_i,
    input  ist0_hazir_o, ist1_hazir_o,
    input  cik_gecerli_o, cik_bayt_o, cik_son_o, cik_kaynak_o
  );
endinterface

// File: rtl/crc16_denetleyici.sv
// ---------------------------------------------------------------------------
// crc16_denetleyici
//   Frame sequencer / arbiter in front of a shared CRC16 engine. Picks one of
//   two requesters, clears the engine, passes the requester's bytes through
//   to the output while feeding each accepted byte to the engine, then
//   appends the CRC (high byte, then low byte marked as last).
//
//   Ports
//     clk_i, rst_i     : clock, asynchronous active-high reset
//     bus (slave)      : requester streams and output stream
//     crc_bayt_o       : byte to the engine
//     crc_etkin_o      : engine enable, high on each accepted data byte
//     crc_temizle_o    : one-cycle engine clear at frame start
//     crc_i            : engine result
//     mesgul_o         : a frame is in progress
//     cerceve_sayac_o  : data bytes of current / most recent frame (saturates)
//
//   Build option
//     CRC16_DEN_RR_EN  : defined -> round-robin on ties,
//                        undefined -> requester 0 wins ties.
// ---------------------------------------------------------------------------
module crc16_denetleyici #(
  parameter int UZUNLUK_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  crc16_denetleyici_if.slave   bus,
  output logic [7:0]           crc_bayt_o,
  output logic                 crc_etkin_o,
  output logic                 crc_temizle_o,
  input  logic [15:0]          crc_i,
  output logic                 mesgul_o,
  output logic [UZUNLUK_W-1:0] cerceve_sayac_o
);

  typedef enum logic [2:0] {BOSTA, TEMIZLE, VERI, CRC_H, CRC_L} durum_t;

  localparam logic [UZUNLUK_W-1:0] SAYAC_BIR = {{(UZUNLUK_W-1){1'b0}}, 1'b1};

  durum_t               state_reg, state_next;
  logic                 grant_reg, grant_next;
  logic                 ptr_reg, ptr_next;
  logic [UZUNLUK_W-1:0] count_reg, count_next;

  logic       sel_gecerli;
  logic [7:0] sel_bayt;
  logic       sel_son;
  logic       kazanan;

  logic       hazir0, hazir1;
  logic       cik_gecerli;
  logic [7:0] cik_bayt;
  logic       cik_son;

  // Granted requester seen through a single mux so VERI is a pure pass-through.
  assign sel_gecerli = grant_reg ? bus.ist1_gecerli_i : bus.ist0_gecerli_i;
  assign sel_bayt    = grant_reg ? bus.ist1_bayt_i    : bus.ist0_bayt_i;
  assign sel_son     = grant_reg ? bus.ist1_son_i     : bus.ist0_son_i;

  // Winner when leaving BOSTA. A lone requester always wins.
`ifdef CRC16_DEN_RR_EN
  assign kazanan = (bus.ist0_gecerli_i && bus.ist1_gecerli_i) ? ~ptr_reg
                                                              : ~bus.ist0_gecerli_i;
`else
  assign kazanan = ~bus.ist0_gecerli_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= BOSTA;
      grant_reg <= 1'b0;
      ptr_reg   <= 1'b1;   // last winner = 1, so requester 0 wins first
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    ptr_next      = ptr_reg;
    count_next    = count_reg;
    hazir0        = 1'b0;
    hazir1        = 1'b0;
    cik_gecerli   = 1'b0;
    cik_bayt      = 8'h00;
    cik_son       = 1'b0;
    crc_bayt_o    = 8'h00;
    crc_etkin_o   = 1'b0;
    crc_temizle_o = 1'b0;

    case (state_reg)
      BOSTA: begin
        if (bus.ist0_gecerli_i || bus.ist1_gecerli_i) begin
          grant_next = kazanan;
          state_next = TEMIZLE;
        end
      end

      TEMIZLE: begin
        crc_temizle_o = 1'b1;
        count_next    = '0;
        state_next    = VERI;
      end

      VERI: begin
        cik_gecerli = sel_gecerli;
        cik_bayt    = sel_bayt;
        hazir0      = ~grant_reg & bus.cik_hazir_i;
        hazir1      =  grant_reg & bus.cik_hazir_i;
        if (sel_gecerli && bus.cik_hazir_i) begin
          crc_etkin_o = 1'b1;
          crc_bayt_o  = sel_bayt;
          if (count_reg != '1) begin
            count_next = count_reg + SAYAC_BIR;
          end
          if (sel_son) begin
            state_next = CRC_H;
          end
        end
      end

      // Engine is idle here, so crc_i holds steady under backpressure.
      CRC_H: begin
        cik_gecerli = 1'b1;
        cik_bayt    = crc_i[15:8];
        if (bus.cik_hazir_i) begin
          state_next = CRC_L;
        end
      end

      CRC_L: begin
        cik_gecerli = 1'b1;
        cik_bayt    = crc_i[7:0];
        cik_son     = 1'b1;
        if (bus.cik_hazir_i) begin
          ptr_next   = grant_reg;
          state_next = BOSTA;
        end
      end

      default: begin
        state_next = BOSTA;
      end
    endcase
  end

  assign bus.ist0_hazir_o  = hazir0;
  assign bus.ist1_hazir_o  = hazir1;
  assign bus.cik_gecerli_o = cik_gecerli;
  assign bus.cik_bayt_o    = cik_bayt;
  assign bus.cik_son_o     = cik_son;
  assign bus.cik_kaynak_o  = grant_reg;
  assign mesgul_o          = (state_reg != BOSTA);
  assign cerceve_sayac_o   = count_reg;

endmodule

// File: tb/tb_crc16_denetleyici.sv
// ---------------------------------------------------------------------------
// tb_crc16_denetleyici
//   Directed bench for the CRC16 frame sequencer. A behavioural CRC-16
//   (poly 0x1021, init 0xFFFF) engine is attached to the engine ports; the
//   expected frame is the data bytes followed by the reference CRC of those
//   bytes. Counter width is shrunk to 3 bits so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_crc16_denetleyici;
  localparam int W = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [7:0]   crc_bayt_o;
  logic         crc_etkin_o;
  logic         crc_temizle_o;
  logic [15:0]  crc_i;
  logic         mesgul_o;
  logic [W-1:0] cerceve_sayac_o;

  always #5 clk_i = ~clk_i;

  crc16_denetleyici_if bus();

  crc16_denetleyici #(.UZUNLUK_W(W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .bus             (bus),
    .crc_bayt_o      (crc_bayt_o),
    .crc_etkin_o     (crc_etkin_o),
    .crc_temizle_o   (crc_temizle_o),
    .crc_i           (crc_i),
    .mesgul_o        (mesgul_o),
    .cerceve_sayac_o (cerceve_sayac_o)
  );

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Engine model: synchronous clear, update on enable.
  logic [15:0] eng_reg;
  always @(posedge clk_i) begin
    if (crc_temizle_o) eng_reg <= 16'hFFFF;
    else if (crc_etkin_o) eng_reg <= crc_upd(eng_reg, crc_bayt_o);
  end
  assign crc_i = eng_reg;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [7:0]  exp_q[$];
  logic [9:0]  out_q[$];
  logic [7:0]  eng_q[$];
  logic        grant_q[$];
  int          clr_cnt, flag_lose, flag_stall;
  logic        hs0, hs1;
  int          stall_left, stall_a, stall_b;
  logic        stall_en, done_a, done_b;
  logic        prev_stalled;
  logic [7:0]  prev_byte;
  logic [15:0] basic_crc, tmp_crc;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {5'd0, bus.cik_gecerli_o, bus.cik_son_o, bus.cik_bayt_o, bus.cik_kaynak_o,
            bus.ist0_hazir_o, bus.ist1_hazir_o, crc_bayt_o, crc_etkin_o,
            crc_temizle_o, mesgul_o, cerceve_sayac_o};
  endfunction

  task automatic drive();
    bus.ist0_gecerli_i = (q0.size() > 0);
    {bus.ist0_son_i, bus.ist0_bayt_i} = (q0.size() > 0) ? q0[0] : 9'h000;
    bus.ist1_gecerli_i = (q1.size() > 0);
    {bus.ist1_son_i, bus.ist1_bayt_i} = (q1.size() > 0) ? q1[0] : 9'h000;
  endtask

  task automatic push_byte(input logic src, input logic [7:0] b, input logic last);
    if (src) q1.push_back({last, b});
    else     q0.push_back({last, b});
    exp_q.push_back(b);
  endtask

  task automatic clear_mon();
    out_q.delete(); eng_q.delete(); grant_q.delete(); exp_q.delete();
    clr_cnt = 0; flag_lose = 0; flag_stall = 0; prev_stalled = 1'b0;
  endtask

  // One clock: sample at negedge, update stimulus just after posedge.
  task automatic cycle();
    @(negedge clk_i);
    hs0 = bus.ist0_gecerli_i & bus.ist0_hazir_o;
    hs1 = bus.ist1_gecerli_i & bus.ist1_hazir_o;
    if (bus.cik_gecerli_o && bus.cik_hazir_i) begin
      out_q.push_back({bus.cik_kaynak_o, bus.cik_son_o, bus.cik_bayt_o});
      if (bus.cik_son_o) grant_q.push_back(bus.cik_kaynak_o);
    end
    if (crc_temizle_o) clr_cnt++;
    if (crc_etkin_o) eng_q.push_back(crc_bayt_o);
    if (mesgul_o ? (bus.cik_kaynak_o ? bus.ist0_hazir_o : bus.ist1_hazir_o)
                 : (bus.ist0_hazir_o | bus.ist1_hazir_o)) flag_lose++;
    if (!bus.cik_hazir_i) begin
      if (hs0 || hs1 || crc_etkin_o) flag_stall++;
      if (prev_stalled && bus.cik_gecerli_o && (bus.cik_bayt_o !== prev_byte)) flag_stall++;
      prev_stalled = bus.cik_gecerli_o;
      prev_byte    = bus.cik_bayt_o;
    end else begin
      prev_stalled = 1'b0;
    end
    @(posedge clk_i);
    #1;
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    if (stall_en && !done_a && out_q.size() == stall_a) begin stall_left = 3; done_a = 1'b1; end
    if (stall_en && !done_b && out_q.size() == stall_b) begin stall_left = 3; done_b = 1'b1; end
    if (stall_left > 0) begin bus.cik_hazir_i = 1'b0; stall_left--; end
    else bus.cik_hazir_i = 1'b1;
    drive();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin cycle(); k++; end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((mesgul_o || q0.size() > 0 || q1.size() > 0) && k < budget) begin cycle(); k++; end
    check_eq({tag, " idle"}, {31'd0, mesgul_o}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic src, input int cnt,
                             output logic [15:0] crc);
    int n;
    logic [15:0] c;
    logic [9:0]  eb, ab;
    n = exp_q.size();
    c = 16'hFFFF;
    foreach (exp_q[i]) c = crc_upd(c, exp_q[i]);
    crc = c;
    $display("frame %s: src=%0d bytes=%0d beats=%0d crc=0x%04h cnt=%0d",
             tag, src, n, out_q.size(), c, cerceve_sayac_o);
    check_eq({tag, " beats"}, out_q.size(), n + 2);
    for (int i = 0; i < n + 2; i++) begin
      eb = {src, (i == n + 1), (i < n) ? exp_q[i] : ((i == n) ? c[15:8] : c[7:0])};
      ab = (i < out_q.size()) ? out_q[i] : 10'h3FF;
      check_eq($sformatf("%s beat%0d", tag, i), ab, eb);
    end
    check_eq({tag, " engine bytes"}, eng_q.size(), n);
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s eng%0d", tag, i),
               (i < eng_q.size()) ? {1'b0, eng_q[i]} : 9'h100, {1'b0, exp_q[i]});
    check_eq({tag, " clear pulses"}, clr_cnt, 1);
    check_eq({tag, " count"}, cerceve_sayac_o, cnt);
    check_eq({tag, " kaynak"}, bus.cik_kaynak_o, src);
    check_eq({tag, " loser hazir"}, flag_lose, 0);
  endtask

  initial begin
    logic exp_g[$];
    rst_i = 1'b1;
    bus.cik_hazir_i = 1'b1;
    stall_en = 1'b0; stall_left = 0; done_a = 1'b0; done_b = 1'b0;
    stall_a = 0; stall_b = 0;
    clear_mon();
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("reset outputs", out_vec(), 32'd0);
    rst_i = 1'b0;
    #1;
    check_eq("idle outputs", out_vec(), 32'd0);

    // Basic 4-byte frame from requester 0.
    clear_mon();
    push_byte(1'b0, 8'h04, 1'b0); push_byte(1'b0, 8'h03, 1'b0);
    push_byte(1'b0, 8'h02, 1'b0); push_byte(1'b0, 8'h01, 1'b1);
    drive();
    wait_beats(6, 40);
    wait_idle("basic", 20);
    check_frame("basic", 1'b0, 4, basic_crc);

    // Single-byte frame from requester 1.
    clear_mon();
    push_byte(1'b1, 8'hAA, 1'b1);
    drive();
    wait_beats(3, 30);
    wait_idle("single", 20);
    check_frame("single", 1'b1, 1, tmp_crc);

    // Both requesters continuously valid with 2-byte frames.
    clear_mon();
    for (int f = 0; f < 3; f++) begin
      q0.push_back({1'b0, 8'h10 + 8'(f)}); q0.push_back({1'b1, 8'h20 + 8'(f)});
      q1.push_back({1'b0, 8'h30 + 8'(f)}); q1.push_back({1'b1, 8'h40 + 8'(f)});
    end
    drive();
`ifdef CRC16_DEN_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0};
`endif
    wait_idle("tie", 200);
    $display("tie: %0d frames granted", grant_q.size());
    for (int i = 0; i < exp_g.size(); i++)
      check_eq($sformatf("tie grant%0d", i),
               (i < grant_q.size()) ? {1'b0, grant_q[i]} : 2'b11, {1'b0, exp_g[i]});
    check_eq("tie loser hazir", flag_lose, 0);

    // Backpressure: 3 stalled cycles in VERI, 3 in CRC_H.
    clear_mon();
    stall_en = 1'b1; stall_a = 2; stall_b = 4; done_a = 1'b0; done_b = 1'b0;
    push_byte(1'b0, 8'h04, 1'b0); push_byte(1'b0, 8'h03, 1'b0);
    push_byte(1'b0, 8'h02, 1'b0); push_byte(1'b0, 8'h01, 1'b1);
    drive();
    wait_beats(6, 60);
    wait_idle("stall", 20);
    stall_en = 1'b0;
    check_frame("stall", 1'b0, 4, tmp_crc);
    check_eq("stall both applied", {30'd0, done_a, done_b}, 32'd3);
    check_eq("stall activity", flag_stall, 0);

    // 9-byte frame saturates the 3-bit counter at 7.
    clear_mon();
    for (int i = 0; i < 9; i++) push_byte(1'b0, 8'h50 + 8'(i), (i == 8));
    drive();
    wait_beats(11, 60);
    wait_idle("sat", 20);
    check_frame("sat", 1'b0, 7, tmp_crc);

    // Reset after two data bytes, then a fresh frame.
    clear_mon();
    push_byte(1'b0, 8'h04, 1'b0); push_byte(1'b0, 8'h03, 1'b0);
    push_byte(1'b0, 8'h02, 1'b0); push_byte(1'b0, 8'h01, 1'b1);
    drive();
    wait_beats(2, 30);
    check_eq("pre-reset beats", out_q.size(), 2);
    rst_i = 1'b1;
    #1;
    check_eq("mid-frame reset outputs", out_vec(), 32'd0);
    q0.delete(); q1.delete();
    drive();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    clear_mon();
    push_byte(1'b0, 8'h04, 1'b0); push_byte(1'b0, 8'h03, 1'b0);
    push_byte(1'b0, 8'h02, 1'b0); push_byte(1'b0, 8'h01, 1'b1);
    drive();
    wait_beats(6, 40);
    wait_idle("after_rst", 20);
    check_frame("after_rst", 1'b0, 4, tmp_crc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/crc16_denetleyici.md
# crc16_denetleyici

Frame-level sequencer and arbiter for the shared `crc16` engine. Two byte-stream requesters compete for one CRC16 engine. The winning requester's frame is passed through to a single output stream. The block clears the engine at frame start, feeds it every accepted byte, and appends the 16-bit CRC (high byte first) after the requester's last byte. It sits between the packet sources and the transmit path, and owns the engine's byte, enable and clear inputs.

## Interface
- `UZUNLUK_W`, 16: width of the frame byte counter.

- `clk_i` input 1: clock; all state changes on rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `ist0_gecerli_i` / `ist1_gecerli_i` input 1: requester byte valid.
- `ist0_bayt_i` / `ist1_bayt_i` input 8: requester data byte.
- `ist0_son_i` / `ist1_son_i` input 1: marks the last data byte of the frame.
- `ist0_hazir_o` / `ist1_hazir_o` output 1: requester byte accepted when valid and ready are both high.
- `cik_gecerli_o` output 1: output byte valid.
- `cik_bayt_o` output 8: output byte.
- `cik_son_o` output 1: last beat of the frame, which is the CRC low byte.
- `cik_kaynak_o` output 1: index of the granted requester.
- `cik_hazir_i` input 1: downstream ready.
- `crc_bayt_o` output 8: byte to the engine (`byte_i`).
- `crc_etkin_o` output 1: engine enable (`etkin_i`).
- `crc_temizle_o` output 1: one-cycle engine clear. Integration combines it into the engine's active-low reset.
- `crc_i` input 16: engine result (`crc16_o`).
- `mesgul_o` output 1: high whenever the state is not BOSTA.
- `cerceve_sayac_o` output UZUNLUK_W: data bytes accepted in the current or most recent frame.

## Operation
The block is a state machine with states BOSTA, TEMIZLE, VERI, CRC_H and CRC_L.

- **BOSTA**
  - If either valid input is high, arbitrate, register the grant into `cik_kaynak_o`, and go to TEMIZLE.
  - If neither is high, stay in BOSTA.
- **TEMIZLE** (one cycle)
  - `crc_temizle_o`=1.
  - `cerceve_sayac_o` is set to 0.
  - Go to VERI.
- **VERI** (combinational pass-through of the granted requester)
  - `cik_gecerli_o` and `cik_bayt_o` come from the granted requester.
  - `cik_son_o`=0.
  - The granted requester's `hazir_o` equals `cik_hazir_i`. The other requester's `hazir_o` is 0.
  - On each handshake, in the same cycle: `crc_etkin_o`=1, `crc_bayt_o` is the accepted byte, and the counter increments.
  - The counter saturates at all-ones.
  - A handshake with `son`=1 moves to CRC_H.
- **CRC_H**
  - `cik_gecerli_o`=1, `cik_bayt_o`=`crc_i[15:8]`.
  - On handshake, go to CRC_L.
- **CRC_L**
  - `cik_gecerli_o`=1, `cik_bayt_o`=`crc_i[7:0]`, `cik_son_o`=1.
  - On handshake, update the arbitration pointer and go to BOSTA.
- **Default outputs:** `crc_etkin_o`=0 and `crc_bayt_o`=0 when there is no VERI handshake.
- **Arbitration**
  - The pointer holds the last winner and resets to 1, so requester 0 wins first.
  - If only one requester is valid, it wins.
- **Boundary conditions**
  - A requester that drops valid mid-frame keeps the grant. The block waits in VERI.
  - A non-granted request stays pending with `hazir_o`=0 and is never dropped.
  - Backpressure in CRC_H or CRC_L holds the output byte stable. `crc_i` is stable because the engine is not enabled.
  - A single-byte frame is legal: three output beats.
  - Reset mid-frame aborts to BOSTA. The downstream frame is truncated without `cik_son_o`.

## Timing
- **Reset values:** all outputs are 0, the state is BOSTA, and the pointer is 1.
- **Request to first output:** a valid input first seen in BOSTA at edge N gives TEMIZLE in cycle N+1. The first byte can be presented in cycle N+2.
- **VERI data path:** zero-latency combinational, from requester to output and from `cik_hazir_i` to `hazir_o`.
- **Engine latency:** the last data byte is accepted at edge M. `crc_i` is final from cycle M+1, which is the first CRC_H cycle.
- **Frame overhead:** minimum 2 CRC beats plus 1 BOSTA cycle plus 1 TEMIZLE cycle. Frames are never interleaved.

## Configuration
- `CRC16_DEN_RR_EN` defined: round-robin. When both requesters are valid in BOSTA, the one that is not the pointer wins.
- `CRC16_DEN_RR_EN` undefined: fixed priority, requester 0 always wins ties. The pointer register is still present but is ignored.

## Test plan
- **Basic frame:**
  - Stimulus: `ist0` sends 04, 03, 02, 01 with `son` on 01, with `cik_hazir_i`=1.
  - Response: output 04, 03, 02, 01, then `crc_i[15:8]`, then `crc_i[7:0]`, with both CRC bytes equal to the model CRC16 of those bytes.
  - `cik_son_o` is high only on the last beat, `cerceve_sayac_o`=4, `cik_kaynak_o`=0, and there is exactly one `crc_temizle_o` pulse.
- **Tie arbitration:**
  - Stimulus: both requesters are continuously valid with 2-byte frames.
  - Response with the macro: grant order 0, 1, 0, 1. Without the macro: 0, 0, 0.
  - The losing requester's `hazir_o` stays 0.
- **Backpressure:**
  - Stimulus: `cik_hazir_i`=0 for 3 cycles in VERI and 3 cycles in CRC_H.
  - Response: no requester handshake and `crc_etkin_o`=0 during the stall. The CRC high byte holds, and the CRC values are unchanged versus the unstalled run.
- **Single byte:**
  - Stimulus: `ist1` sends AA with `son`.
  - Response: 3 beats (AA, CRC high, CRC low), `cerceve_sayac_o`=1, `cik_kaynak_o`=1.
- **Reset mid-frame:**
  - Stimulus: assert `rst_i` after 2 bytes.
  - Response: all outputs are 0 immediately. A new `ist0` frame 04, 03, 02, 01 afterwards yields the same CRC as the basic-frame test, proving the engine was cleared.
